cla16_shared_sequencer: RTL and testbench
=========================================

// Module: cla16_shared_sequencer
// PURPOSE
//  Shares one 16-bit lookahead adder (CLA_16bit_withLCU, instantiated inside) between two requesters.
//  Each request is a wide add of 16*WORDS bits, run one 16-bit slice per cycle, LSB slice first.
//  The carry out of each slice is registered and fed into the next slice.
//  Sits between client datapaths and the adder: round-robin arbitration, operand capture, carry sequencing.
// PARAMETERS
//  WORDS  4  number of 16-bit slices per operand; legal range 1..8; operand width W = 16*WORDS
// PORTS
//  clk      in   1   clock; all state updates on rising edge
//  rst      in   1   asynchronous reset, active-high
//  req0     in   1   requester 0 has an operation pending; held until gnt0
//  a0       in   W   requester 0 operand A
//  b0       in   W   requester 0 operand B
//  cin0     in   1   requester 0 carry in
//  gnt0     out  1   1-cycle grant; a0/b0/cin0 sampled at this clock edge
//  req1     in   1   requester 1 has an operation pending; held until gnt1
//  a1       in   W   requester 1 operand A
//  b1       in   W   requester 1 operand B
//  cin1     in   1   requester 1 carry in
//  gnt1     out  1   1-cycle grant; a1/b1/cin1 sampled at this clock edge
//  busy     out  1   high in RUN and DONE
//  done     out  1   1-cycle pulse: sum/cout/done_id are valid
//  done_id  out  1   requester that owns the result
//  sum      out  W   registered wide sum
//  cout     out  1   carry out of the MSB slice
// BEHAVIOUR
//  Reset (async): state=IDLE, slice counter k=0, carry reg=0, last_id=1, sum=0, cout=0, done=0, done_id=0.
//  While rst is high, gnt0 and gnt1 are 0.
//  Reset mid-operation aborts the op immediately. No done is issued for it, and the requester is not re-granted.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//  IDLE
//   - gnt is combinational from state, req and last_id.
//   - Only req0 high: gnt0=1. Only req1 high: gnt1=1.
//   - Both high: grant goes to the requester != last_id.
//   - On a grant edge: capture A, B, cin into internal regs; carry reg<=cin; k<=0; last_id<=winner; go to RUN.
//   - No req: stay in IDLE, both gnt low.
//   - A requester may drop req before its grant (withdraw). No grant is issued for a withdrawn request.
//  RUN, cycle k
//   - Adder inputs: A[16k+15:16k], B[16k+15:16k], carry reg.
//   - sum[16k+15:16k] <= slice sum; carry reg <= slice carry out.
//   - k == WORDS-1: cout <= slice carry out; go to DONE. Otherwise k <= k+1.
//  DONE
//   - done=1 and done_id=last_id for exactly one cycle; next state IDLE.
//   - sum/cout hold until overwritten by the next operation's RUN cycles.
//  Timing
//   - Grant at edge T: done high in cycle T+WORDS+1. Next grant possible at edge T+WORDS+2.
//   - A request is never granted in RUN or DONE; req held through that time is simply kept pending.
//  Arithmetic is unsigned modulo 2^W, with cout as bit W.
//  The slice counter is 3 bits and never wraps past WORDS-1.
// CONFIGURATION
//  CLA16_SEQ_OVF_EN defined
//   - Adds output port ovf (1 bit), reset 0.
//   - Updated on the MSB-slice edge: ovf <= (A[W-1]==B[W-1]) && (slice sum MSB != A[W-1]).
//   - This is two's-complement signed overflow; valid with done and held like sum.
//  CLA16_SEQ_OVF_EN not defined
//   - Port ovf and its logic are absent; all other behaviour is identical.
// TESTING  (WORDS=4 unless stated)
//  1. req0, a0=0x0000_0000_0000_FFFF, b0=1, cin0=0 -> gnt0 at edge T; done at T+5;
//     sum=0x0000_0000_0001_0000, cout=0, done_id=0.
//  2. req1, a1=0xFFFF_FFFF_FFFF_FFFF, b1=0, cin1=1 -> sum=0, cout=1, done_id=1 (carry ripples through all 4 slices).
//  3. req0 and req1 both held from reset -> gnt0, done_id=0, then gnt1, done_id=1; re-raise both -> gnt0 again.
//     No grant while busy=1.
//  4. rst pulsed during RUN with k=2 -> sum=0, busy=0, no done; a following req0 completes normally with correct sum.
//  5. CLA16_SEQ_OVF_EN defined, a0=0x7FFF_FFFF_FFFF_FFFF, b0=1 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
//     Then a0=b0=0x4000_0000_0000_0000 -> ovf=1; a0=1, b0=1 -> ovf=0.
//  6. WORDS=1, req0, a0=0xFFFF, b0=0x0001 -> done at T+2, sum=0x0000, cout=1.
//     req0 withdrawn before grant -> no gnt0, no done.

Source files
------------

// File: rtl/cla16_shared_sequencer.sv
// ---------------------------------------------------------------------------
// cla16_shared_sequencer
//   Shares a single 16-bit lookahead adder between two requesters. Each
//   request is a 16*WORDS-bit add executed one 16-bit slice per cycle, LSB
//   slice first, with the slice carry registered between cycles.
//   Arbitration is round-robin; operands are captured on the grant edge.
//
//   Optional feature: define CLA16_SEQ_OVF_EN to add the 'ovf' output
//   (two's-complement signed overflow of the wide add).
//
// Ports
//   clk              clock, rising edge
//   rst              asynchronous reset, active-high
//   req0/req1        request, held until the matching grant
//   a0,b0,cin0       requester 0 operands (sampled on the gnt0 edge)
//   a1,b1,cin1       requester 1 operands (sampled on the gnt1 edge)
//   gnt0/gnt1        1-cycle grant, combinational in IDLE
//   busy             high while running or presenting the result
//   done             1-cycle pulse: sum/cout/done_id (and ovf) are valid
//   done_id          requester owning the result
//   sum              registered wide sum, held until the next op overwrites it
//   cout             carry out of the MSB slice
//   ovf              (CLA16_SEQ_OVF_EN only) signed overflow, held like sum
//
// Also contains CLA_16bit_withLCU: 4x4-bit carry-lookahead groups joined by
// a lookahead carry unit.
// ---------------------------------------------------------------------------
module cla16_shared_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [16*WORDS-1:0]   a0,
  input  logic [16*WORDS-1:0]   b0,
  input  logic                  cin0,
  output logic                  gnt0,
  input  logic                  req1,
  input  logic [16*WORDS-1:0]   a1,
  input  logic [16*WORDS-1:0]   b1,
  input  logic                  cin1,
  output logic                  gnt1,
  output logic                  busy,
  output logic                  done,
  output logic                  done_id,
  output logic [16*WORDS-1:0]   sum,
`ifdef CLA16_SEQ_OVF_EN
  output logic                  ovf,
`endif
  output logic                  cout
);

  localparam int W = 16 * WORDS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] K_LAST = 3'(WORDS - 1);

  logic [1:0]   state_q, state_d;
  logic [2:0]   k_q;
  logic         carry_q;
  logic         last_id_q;
  logic [W-1:0] a_q, b_q;
  logic [W-1:0] sum_q, sum_d;
  logic         cout_q;
  logic         done_q;
  logic         done_id_q;
`ifdef CLA16_SEQ_OVF_EN
  logic         ovf_q;
`endif

  logic [15:0]  a_sl, b_sl, slice_sum;
  logic         slice_cout;
  logic         grant;
  logic         last_slice;

  // Round-robin: on contention the requester that did not win last time
  // gets the grant. Grants are suppressed while reset is asserted.
  assign gnt0  = !rst && (state_q == ST_IDLE) && req0 && (!req1 || last_id_q);
  assign gnt1  = !rst && (state_q == ST_IDLE) && req1 && (!req0 || !last_id_q);
  assign grant = gnt0 || gnt1;

  assign last_slice = (k_q == K_LAST);

  // Select the current 16-bit slice of the captured operands.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (k_q == 3'(i)) begin
        a_sl = a_q[i*16 +: 16];
        b_sl = b_q[i*16 +: 16];
      end
    end
  end

  CLA_16bit_withLCU u_cla (
    .a_i    (a_sl),
    .b_i    (b_sl),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // Only the slice addressed by k is rewritten during RUN; others hold.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_sum_slice
      assign sum_d[gi*16 +: 16] = ((state_q == ST_RUN) && (k_q == 3'(gi)))
                                  ? slice_sum : sum_q[gi*16 +: 16];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant) state_d = ST_RUN;
      ST_RUN:  if (last_slice) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      k_q       <= 3'd0;
      carry_q   <= 1'b0;
      last_id_q <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
`ifdef CLA16_SEQ_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            a_q       <= gnt0 ? a0 : a1;
            b_q       <= gnt0 ? b0 : b1;
            carry_q   <= gnt0 ? cin0 : cin1;
            k_q       <= 3'd0;
            last_id_q <= gnt1;
          end
        end
        ST_RUN: begin
          carry_q <= slice_cout;
          if (last_slice) begin
            cout_q    <= slice_cout;
            done_q    <= 1'b1;
            done_id_q <= last_id_q;
`ifdef CLA16_SEQ_OVF_EN
            // Same-sign operands producing a different-sign result.
            ovf_q     <= (a_sl[15] == b_sl[15]) && (slice_sum[15] != a_sl[15]);
`endif
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done    = done_q;
  assign done_id = done_id_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
`ifdef CLA16_SEQ_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule

// ---------------------------------------------------------------------------
// CLA_16bit_withLCU
//   16-bit carry-lookahead adder: four 4-bit lookahead groups, group
//   propagate/generate combined in a second-level lookahead carry unit.
// Ports
//   a_i, b_i   16-bit operands
//   cin_i      carry in
//   sum_o      16-bit sum
//   cout_o     carry out
// ---------------------------------------------------------------------------
module CLA_16bit_withLCU (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [15:0] p, g, c;
  logic [3:0]  gp, gg;
  logic [4:0]  gc;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_group
      assign gp[gi] = &p[4*gi +: 4];
      assign gg[gi] = g[4*gi+3]
                    | (p[4*gi+3] & g[4*gi+2])
                    | (p[4*gi+3] & p[4*gi+2] & g[4*gi+1])
                    | (p[4*gi+3] & p[4*gi+2] & p[4*gi+1] & g[4*gi]);
      // Bit carries inside the group, all derived from the group carry-in.
      assign c[4*gi]   = gc[gi];
      assign c[4*gi+1] = g[4*gi] | (p[4*gi] & gc[gi]);
      assign c[4*gi+2] = g[4*gi+1] | (p[4*gi+1] & g[4*gi])
                       | (p[4*gi+1] & p[4*gi] & gc[gi]);
      assign c[4*gi+3] = g[4*gi+2] | (p[4*gi+2] & g[4*gi+1])
                       | (p[4*gi+2] & p[4*gi+1] & g[4*gi])
                       | (p[4*gi+2] & p[4*gi+1] & p[4*gi] & gc[gi]);
    end
  endgenerate

  // Lookahead carry unit over the four groups.
  assign gc[0] = cin_i;
  assign gc[1] = gg[0] | (gp[0] & cin_i);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin_i);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin_i);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin_i);

  assign sum_o  = p ^ c;
  assign cout_o = gc[4];

endmodule

// File: tb/tb_cla16_shared_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for cla16_shared_sequencer: a WORDS=4 instance (main tests) and a
// WORDS=1 instance (single-slice timing and request withdrawal). Stimulus
// pushes expected results on each observed grant; monitors pop on done.
// ---------------------------------------------------------------------------
module tb_cla16_shared_sequencer;

  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          compares = 0;
  int          fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- WORDS=4 instance ----------------
  logic        req0, req1, cin0, cin1, gnt0, gnt1, busy, done, done_id, cout;
  logic [63:0] a0, b0, a1, b1, sum;
`ifdef CLA16_SEQ_OVF_EN
  logic        ovf;
`endif

  cla16_shared_sequencer #(.WORDS(WORDS)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .cin0(cin0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .cin1(cin1), .gnt1(gnt1),
    .busy(busy), .done(done), .done_id(done_id), .sum(sum),
`ifdef CLA16_SEQ_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  // ---------------- WORDS=1 instance ----------------
  logic        s_req0, s_req1, s_cin0, s_cin1, s_gnt0, s_gnt1;
  logic        s_busy, s_done, s_done_id, s_cout;
  logic [15:0] s_a0, s_b0, s_a1, s_b1, s_sum;
`ifdef CLA16_SEQ_OVF_EN
  logic        s_ovf;
`endif

  cla16_shared_sequencer #(.WORDS(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req0(s_req0), .a0(s_a0), .b0(s_b0), .cin0(s_cin0), .gnt0(s_gnt0),
    .req1(s_req1), .a1(s_a1), .b1(s_b1), .cin1(s_cin1), .gnt1(s_gnt1),
    .busy(s_busy), .done(s_done), .done_id(s_done_id), .sum(s_sum),
`ifdef CLA16_SEQ_OVF_EN
    .ovf(s_ovf),
`endif
    .cout(s_cout)
  );

  typedef struct {
    int          id;
    logic [63:0] s;
    logic        co;
    logic        ov;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [63:0] exp_sum [2];
  logic        exp_cout [2];
  logic        exp_ovf [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    compares++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) chk("no_grant_while_busy", 64'(gnt0 | gnt1), 64'd0);
      if (done) begin
        if (q0.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q0.pop_front();
          $display("done id=%0d sum=%h cout=%0d cycle=%0d", done_id, sum, cout, cyc);
          chk("done_id", 64'(done_id), 64'(e.id));
          chk("sum", sum, e.s);
          chk("cout", 64'(cout), 64'(e.co));
          chk("done_cycle", 64'(cyc), 64'(e.due));
`ifdef CLA16_SEQ_OVF_EN
          chk("ovf", 64'(ovf), 64'(e.ov));
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s_done) begin
      if (q1.size() == 0) begin
        chk("w1_unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        $display("w1 done id=%0d sum=%h cout=%0d cycle=%0d", s_done_id, s_sum, s_cout, cyc);
        chk("w1_done_id", 64'(s_done_id), 64'(e.id));
        chk("w1_sum", 64'(s_sum), e.s);
        chk("w1_cout", 64'(s_cout), 64'(e.co));
        chk("w1_done_cycle", 64'(cyc), 64'(e.due));
`ifdef CLA16_SEQ_OVF_EN
        chk("w1_ovf", 64'(s_ovf), 64'(e.ov));
`endif
      end
    end
  end

  // Wait (bounded) for a grant on the WORDS=4 instance, push the expectation
  // for the winner, then drop its request after the grant edge.
  task automatic wait_grant(output int who, input bit push);
    exp_t e;
    who = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        chk("single_grant", 64'(gnt0 & gnt1), 64'd0);
        who = gnt0 ? 0 : 1;
        break;
      end
    end
    if (who < 0) begin
      chk("grant_timeout", 64'd1, 64'd0);
    end else begin
      $display("grant id=%0d cycle=%0d", who, cyc);
      if (push) begin
        e.id  = who;
        e.s   = exp_sum[who];
        e.co  = exp_cout[who];
        e.ov  = exp_ovf[who];
        e.due = cyc + 1 + WORDS;
        q0.push_back(e);
      end
      @(posedge clk);
      #1;
      if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    end
  endtask

  task automatic issue(input int id, input logic [63:0] a, input logic [63:0] b,
                       input logic c, input logic [63:0] es, input logic eco,
                       input logic eov);
    int w;
    exp_sum[id] = es; exp_cout[id] = eco; exp_ovf[id] = eov;
    if (id == 0) begin a0 = a; b0 = b; cin0 = c; req0 = 1'b1; end
    else         begin a1 = a; b1 = b; cin1 = c; req1 = 1'b1; end
    wait_grant(w, 1'b1);
    chk("grant_owner", 64'(w), 64'(id));
  endtask

  task automatic set_pair();
    a0 = 64'h1234_5678_9ABC_DEF0; b0 = 64'h1111_1111_1111_1111; cin0 = 1'b0;
    exp_sum[0] = 64'h2345_6789_ABCD_F001; exp_cout[0] = 1'b0; exp_ovf[0] = 1'b0;
    a1 = 64'h8000_0000_0000_0001; b1 = 64'h8000_0000_0000_0001; cin1 = 1'b1;
    exp_sum[1] = 64'h0000_0000_0000_0003; exp_cout[1] = 1'b1; exp_ovf[1] = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
  endtask

  initial begin
    int   w;
    exp_t e;
    rst = 1'b0;
    s_req0 = 1'b0; s_req1 = 1'b0; s_cin0 = 1'b0; s_cin1 = 1'b0;
    s_a0 = '0; s_b0 = '0; s_a1 = '0; s_b1 = '0;
    set_pair();                       // both requests held from reset
    #1 rst = 1'b1;

    // Reset state; grants stay low while rst is high.
    @(negedge clk);
    chk("rst_gnt0", 64'(gnt0), 64'd0);
    chk("rst_gnt1", 64'(gnt1), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_done_id", 64'(done_id), 64'd0);
    chk("rst_sum", sum, 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Contention: 0 first (last_id resets to 1), then 1; again 0 first.
    wait_grant(w, 1'b1); chk("rr_first", 64'(w), 64'd0);
    wait_grant(w, 1'b1); chk("rr_second", 64'(w), 64'd1);
    set_pair();
    wait_grant(w, 1'b1); chk("rr_third", 64'(w), 64'd0);
    wait_grant(w, 1'b1); chk("rr_fourth", 64'(w), 64'd1);

    // Carry across slice boundary; carry ripple through all slices.
    issue(0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);

    // Reset while k=2: no done, sum cleared, then a normal op.
    exp_sum[0] = 64'd0; exp_cout[0] = 1'b0; exp_ovf[0] = 1'b0;
    a0 = 64'hFFFF_FFFF_FFFF_FFFF; b0 = 64'hFFFF_FFFF_FFFF_FFFF; cin0 = 1'b0; req0 = 1'b1;
    wait_grant(w, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_sum", sum, 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    issue(0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

    // Signed-overflow vectors (sum/cout checked in every build).
    issue(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    issue(0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0,
          64'h8000_0000_0000_0000, 1'b0, 1'b1);
    issue(0, 64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0);

    // WORDS=1: done at T+2, then a request withdrawn while busy.
    s_a0 = 16'hFFFF; s_b0 = 16'h0001; s_cin0 = 1'b0; s_req0 = 1'b1;
    w = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (s_gnt0) begin w = 0; break; end
    end
    if (w < 0) begin
      chk("w1_grant_timeout", 64'd1, 64'd0);
    end else begin
      $display("w1 grant id=0 cycle=%0d", cyc);
      e.id = 0; e.s = 64'h0000; e.co = 1'b1; e.ov = 1'b0; e.due = cyc + 2;
      q1.push_back(e);
      @(posedge clk); #1;
      s_req0 = 1'b1;                  // raised while RUN, withdrawn before IDLE
      @(negedge clk);
      chk("w1_withdraw_gnt", 64'(s_gnt0), 64'd0);
      s_req0 = 1'b0;
      for (int n = 0; n < 6; n++) begin
        @(negedge clk);
        chk("w1_no_gnt", 64'(s_gnt0), 64'd0);
      end
    end

    // Drain both scoreboards.
    for (int n = 0; n < 50 && (q0.size() != 0 || q1.size() != 0); n++) @(negedge clk);
    chk("pending_main", 64'(q0.size()), 64'd0);
    chk("pending_w1", 64'(q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
